// File: rtl/eth_frame_receiver_if.sv
// -----------------------------------------------------------------------------
// eth_frame_receiver_if
// Bundles the byte-wide receive link and the header / payload / status outputs
// of eth_frame_receiver.
//
// Signal handshake:
//   rx_valid qualifies rx_data on every rising clk edge. It stays high for the
//   whole frame, and its first low cycle marks the end of the frame. There is
//   no ready/backpressure in either direction. pay_valid, hdr_valid and
//   frame_done are single-cycle strobes. The header fields and the status
//   fields hold their values between strobes.
//
// Modports:
//   slave  - the receiver: consumes rx_*, drives the header/payload/status outputs
//   master - the link side / bench: drives rx_*, observes everything else
//
// Optional: ETH_RX_ADDR_FILTER_EN adds my_mac, the station address used by
//   the destination filter.
// dbg_state exposes the receiver FSM state for observation.
// -----------------------------------------------------------------------------
interface eth_frame_receiver_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
`ifdef ETH_RX_ADDR_FILTER_EN
  logic [47:0] my_mac;
`endif
  logic [47:0] dest_mac;
  logic [47:0] src_mac;
  logic [15:0] ethertype;
  logic        hdr_valid;
  logic [7:0]  pay_data;
  logic        pay_valid;
  logic        pay_last;
  logic        frame_done;
  logic        frame_ok;
  logic        crc_err;
  logic        len_err;
  logic [15:0] payload_length;
  logic [2:0]  dbg_state;

  modport slave (
    input  rx_data, rx_valid,
`ifdef ETH_RX_ADDR_FILTER_EN
    input  my_mac,
`endif
    output dest_mac, src_mac, ethertype, hdr_valid,
    output pay_data, pay_valid, pay_last,
    output frame_done, frame_ok, crc_err, len_err, payload_length,
    output dbg_state
  );

  modport master (
    output rx_data, rx_valid,
`ifdef ETH_RX_ADDR_FILTER_EN
    output my_mac,
`endif
    input  dest_mac, src_mac, ethertype, hdr_valid,
    input  pay_data, pay_valid, pay_last,
    input  frame_done, frame_ok, crc_err, len_err, payload_length,
    input  dbg_state
  );
endinterface

// File: rtl/eth_frame_receiver.sv
// -----------------------------------------------------------------------------
// eth_frame_receiver
// Receive side of the byte-wide Ethernet frame link.
//   - strips the preamble (>= PRE_MIN x 0x55) and the SFD (0xD5)
//   - captures the destination MAC, the source MAC and the EtherType, then
//     pulses hdr_valid
//   - streams the payload through a 5-byte delay line, so that the 4 FCS bytes
//     are never emitted
//   - checks the CRC-32 residue and the frame length, then pulses frame_done
//     with the frame status
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - eth_frame_receiver_if.slave (rx link in, header/payload/status out)
//
// Parameters:
//   MAX_PAYLOAD - largest payload accepted; a longer frame is flagged len_err
//   PRE_MIN     - minimum number of 0x55 bytes required before the SFD
//
// Optional feature, macro ETH_RX_ADDR_FILTER_EN:
//   A unicast frame whose destination does not match bus.my_mac is dropped
//   silently.
// -----------------------------------------------------------------------------
module eth_frame_receiver #(
  parameter int MAX_PAYLOAD = 1500,
  parameter int PRE_MIN     = 7
) (
  input logic             clk,
  input logic             rst,
  eth_frame_receiver_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRE     = 3'd1;
  localparam logic [2:0] S_MAC     = 3'd2;
  localparam logic [2:0] S_TYPE    = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;
  localparam logic [2:0] S_DROP    = 3'd5;

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [3:0]  PRE_MIN_C   = 4'(PRE_MIN);
  localparam logic [15:0] MAX_PAY_C   = 16'(MAX_PAYLOAD);

  // Bitwise reflected CRC-32 update for one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [3:0]       pre_cnt_q, pre_cnt_d;
  logic [3:0]       hdr_cnt_q, hdr_cnt_d;
  logic [103:0]     hdr_sr_q, hdr_sr_d;   // first 13 header bytes, oldest on top
  logic [15:0]      pay_cnt_q, pay_cnt_d; // payload bytes emitted so far
  logic [2:0]       dly_cnt_q, dly_cnt_d;
  logic [4:0][7:0]  dly_q, dly_d;         // entry 0 is the oldest byte
  logic [31:0]      crc_q, crc_d;
  logic             drop_pay_q, drop_pay_d; // S_DROP was entered on oversize

  logic [47:0] dest_mac_q, dest_mac_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [15:0] ethertype_q, ethertype_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic [7:0]  pay_data_q, pay_data_d;
  logic        pay_valid_q, pay_valid_d;
  logic        pay_last_q, pay_last_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_ok_q, frame_ok_d;
  logic        crc_err_q, crc_err_d;
  logic        len_err_q, len_err_d;
  logic [15:0] payload_length_q, payload_length_d;

  logic [31:0] crc_upd;
  logic        eof;

`ifdef ETH_RX_ADDR_FILTER_EN
  logic [47:0] dest_now;
  // The destination address is complete on the cycle its 6th byte arrives.
  assign dest_now = {hdr_sr_q[39:0], bus.rx_data};
`endif

  assign crc_upd = crc32_byte(crc_q, bus.rx_data);

  always_comb begin
    state_d          = state_q;
    pre_cnt_d        = pre_cnt_q;
    hdr_cnt_d        = hdr_cnt_q;
    hdr_sr_d         = hdr_sr_q;
    pay_cnt_d        = pay_cnt_q;
    dly_cnt_d        = dly_cnt_q;
    dly_d            = dly_q;
    crc_d            = crc_q;
    drop_pay_d       = drop_pay_q;
    dest_mac_d       = dest_mac_q;
    src_mac_d        = src_mac_q;
    ethertype_d      = ethertype_q;
    hdr_valid_d      = 1'b0;
    pay_data_d       = pay_data_q;
    pay_valid_d      = 1'b0;
    pay_last_d       = 1'b0;
    frame_done_d     = 1'b0;
    frame_ok_d       = frame_ok_q;
    crc_err_d        = crc_err_q;
    len_err_d        = len_err_q;
    payload_length_d = payload_length_q;
    eof              = 1'b0;

    case (state_q)
      S_IDLE: begin
        crc_d = '1;
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'h55) begin
            state_d   = S_PRE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d    = S_DROP;
            drop_pay_d = 1'b0;
          end
        end
      end

      S_PRE: begin
        crc_d = '1;
        if (!bus.rx_valid) begin
          state_d = S_IDLE;
        end else if (bus.rx_data == 8'h55) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (bus.rx_data == 8'hD5 && pre_cnt_q >= PRE_MIN_C) begin
          state_d   = S_MAC;
          hdr_cnt_d = 4'd0;
          dly_cnt_d = 3'd0;
          pay_cnt_d = 16'd0;
        end else begin
          state_d    = S_DROP;
          drop_pay_d = 1'b0;
        end
      end

      S_MAC, S_TYPE: begin
        if (bus.rx_valid) begin
          crc_d     = crc_upd;
          hdr_sr_d  = {hdr_sr_q[95:0], bus.rx_data};
          hdr_cnt_d = hdr_cnt_q + 4'd1;
          if (hdr_cnt_q == 4'd11) state_d = S_TYPE;
          // The header outputs change only together, when the last EtherType byte arrives.
          if (hdr_cnt_q == 4'd13) begin
            dest_mac_d  = hdr_sr_q[103:56];
            src_mac_d   = hdr_sr_q[55:8];
            ethertype_d = {hdr_sr_q[7:0], bus.rx_data};
            hdr_valid_d = 1'b1;
            state_d     = S_PAYLOAD;
          end
`ifdef ETH_RX_ADDR_FILTER_EN
          if (hdr_cnt_q == 4'd5 && dest_now != bus.my_mac && !dest_now[40]) begin
            state_d    = S_DROP;
            drop_pay_d = 1'b0;
          end
`endif
        end else begin
          eof = 1'b1;
        end
      end

      S_PAYLOAD: begin
        if (bus.rx_valid) begin
          crc_d = crc_upd;
          if (dly_cnt_q == 3'd5) begin
            if (pay_cnt_q == MAX_PAY_C) begin
              state_d    = S_DROP;
              drop_pay_d = 1'b1;
            end else begin
              pay_data_d  = dly_q[0];
              pay_valid_d = 1'b1;
              dly_d       = {bus.rx_data, dly_q[4:1]};
              pay_cnt_d   = pay_cnt_q + 16'd1;
            end
          end else begin
            dly_d[dly_cnt_q] = bus.rx_data;
            dly_cnt_d        = dly_cnt_q + 3'd1;
          end
        end else begin
          eof = 1'b1;
        end
      end

      S_DROP: begin
        if (!bus.rx_valid) begin
          state_d = S_IDLE;
          if (drop_pay_q) begin
            frame_done_d     = 1'b1;
            crc_err_d        = 1'b0;
            len_err_d        = 1'b1;
            frame_ok_d       = 1'b0;
            payload_length_d = pay_cnt_q;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // End of frame inside the header or the payload. The 4 newest buffered
    // bytes are the FCS, so one byte beyond those is the final payload byte.
    if (eof) begin
      state_d      = S_IDLE;
      frame_done_d = 1'b1;
      if (dly_cnt_q == 3'd5) begin
        if (pay_cnt_q == MAX_PAY_C) begin
          crc_err_d        = 1'b0;
          len_err_d        = 1'b1;
          payload_length_d = pay_cnt_q;
        end else begin
          pay_data_d       = dly_q[0];
          pay_valid_d      = 1'b1;
          pay_last_d       = 1'b1;
          crc_err_d        = (crc_q != CRC_RESIDUE);
          len_err_d        = 1'b0;
          payload_length_d = pay_cnt_q + 16'd1;
        end
      end else if (dly_cnt_q == 3'd4) begin
        crc_err_d        = (crc_q != CRC_RESIDUE);
        len_err_d        = 1'b0;
        payload_length_d = 16'd0;
      end else begin
        crc_err_d        = 1'b0;
        len_err_d        = 1'b1;
        payload_length_d = pay_cnt_q;
      end
      frame_ok_d = !(crc_err_d || len_err_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      pre_cnt_q        <= '0;
      hdr_cnt_q        <= '0;
      hdr_sr_q         <= '0;
      pay_cnt_q        <= '0;
      dly_cnt_q        <= '0;
      dly_q            <= '0;
      crc_q            <= '1;
      drop_pay_q       <= 1'b0;
      dest_mac_q       <= '0;
      src_mac_q        <= '0;
      ethertype_q      <= '0;
      hdr_valid_q      <= 1'b0;
      pay_data_q       <= '0;
      pay_valid_q      <= 1'b0;
      pay_last_q       <= 1'b0;
      frame_done_q     <= 1'b0;
      frame_ok_q       <= 1'b0;
      crc_err_q        <= 1'b0;
      len_err_q        <= 1'b0;
      payload_length_q <= '0;
    end else begin
      state_q          <= state_d;
      pre_cnt_q        <= pre_cnt_d;
      hdr_cnt_q        <= hdr_cnt_d;
      hdr_sr_q         <= hdr_sr_d;
      pay_cnt_q        <= pay_cnt_d;
      dly_cnt_q        <= dly_cnt_d;
      dly_q            <= dly_d;
      crc_q            <= crc_d;
      drop_pay_q       <= drop_pay_d;
      dest_mac_q       <= dest_mac_d;
      src_mac_q        <= src_mac_d;
      ethertype_q      <= ethertype_d;
      hdr_valid_q      <= hdr_valid_d;
      pay_data_q       <= pay_data_d;
      pay_valid_q      <= pay_valid_d;
      pay_last_q       <= pay_last_d;
      frame_done_q     <= frame_done_d;
      frame_ok_q       <= frame_ok_d;
      crc_err_q        <= crc_err_d;
      len_err_q        <= len_err_d;
      payload_length_q <= payload_length_d;
    end
  end

  assign bus.dest_mac       = dest_mac_q;
  assign bus.src_mac        = src_mac_q;
  assign bus.ethertype      = ethertype_q;
  assign bus.hdr_valid      = hdr_valid_q;
  assign bus.pay_data       = pay_data_q;
  assign bus.pay_valid      = pay_valid_q;
  assign bus.pay_last       = pay_last_q;
  assign bus.frame_done     = frame_done_q;
  assign bus.frame_ok       = frame_ok_q;
  assign bus.crc_err        = crc_err_q;
  assign bus.len_err        = len_err_q;
  assign bus.payload_length = payload_length_q;
  assign bus.dbg_state      = state_q;

endmodule
